// File: rtl/sr_pulse_gen.sv
// Debounces a raw switch level and emits alternating one-shot set/reset pulses
// suitable for driving a downstream set/reset latch.
module sr_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_WIDTH     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic r,
  output logic level,
  output logic busy
);

  localparam int unsigned CntW = $clog2(255);

  localparam logic [CntW-1:0] DbLast    = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {
    StLow    = 2'd0,
    StDbRise = 2'd1,
    StHigh   = 2'd2,
    StDbFall = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] db_cnt_q, db_cnt_d;
  logic [CntW-1:0] pw_cnt_q, pw_cnt_d;
  logic            sync1_q, sync2_q;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            level_q, level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= StLow;
      db_cnt_q <= '0;
      pw_cnt_q <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      pw_cnt_q <= pw_cnt_d;
      s_q      <= s_d;
      r_q      <= r_d;
      level_q  <= level_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    pw_cnt_d = pw_cnt_q;
    s_d      = s_q;
    r_d      = r_q;
    level_d  = level_q;

    // One shared pulse timer serves whichever of s/r is active.
    if (s_q || r_q) begin
      if (pw_cnt_q == PulseLast) begin
        s_d = 1'b0;
        r_d = 1'b0;
      end else if (pw_cnt_q != '1) begin
        pw_cnt_d = pw_cnt_q + CntW'(1);
      end
    end

    unique case (state_q)
      StLow: begin
        if (!r_q && sync2_q) begin
          state_d  = StDbRise;
          db_cnt_d = '0;
        end
      end
      StDbRise: begin
        if (!sync2_q) begin
          state_d = StLow;
        end else if (db_cnt_q == DbLast) begin
          state_d  = StHigh;
          level_d  = 1'b1;
          s_d      = 1'b1;
          pw_cnt_d = '0;
        end else if (db_cnt_q != '1) begin
          db_cnt_d = db_cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        if (!s_q && !sync2_q) begin
          state_d  = StDbFall;
          db_cnt_d = '0;
        end
      end
      StDbFall: begin
        if (sync2_q) begin
          state_d = StHigh;
        end else if (db_cnt_q == DbLast) begin
          state_d  = StLow;
          level_d  = 1'b0;
          r_d      = 1'b1;
          pw_cnt_d = '0;
        end else if (db_cnt_q != '1) begin
          db_cnt_d = db_cnt_q + CntW'(1);
        end
      end
      default: state_d = StLow;
    endcase
  end

  assign s     = s_q;
  assign r     = r_q;
  assign level = level_q;
  assign busy  = (state_q == StDbRise) || (state_q == StDbFall) || s_q || r_q;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed bench for sr_pulse_gen: a run-length model checked every cycle plus
// hand-computed edge numbers for the key scenarios.
module tb_sr_pulse_gen;

  localparam int DEB = 4;
  localparam int PW  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic s, r, level, busy;

  sr_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_WIDTH    (PW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .s    (s),
    .r    (r),
    .level(level),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: a change is accepted once the synchronized input has disagreed with
  // the accepted level for DEB+1 consecutive edges, the run having started
  // while no pulse was showing.
  logic m_sy1, m_sy2, m_level, m_kind, s2_old, blocked;
  int   m_run, m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sy1 = 1'b0; m_sy2 = 1'b0; m_level = 1'b0; m_kind = 1'b0;
      m_run = 0; m_left = 0;
    end else begin
      s2_old  = m_sy2;
      blocked = (m_left > 0);
      m_sy2   = m_sy1;
      m_sy1   = din;
      if (m_left > 0) m_left--;
      if (s2_old != m_level && (m_run > 0 || !blocked)) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = ~m_level;
          m_kind  = m_level;
          m_left  = PW;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // Compare and event tracking on the falling edge.
  int   s_rise_cyc = -1, s_fall_cyc = -1, r_rise_cyc = -1, busy_rise_cyc = -1;
  int   last_fall = -1, n_pulses = 0;
  logic last_kind = 1'b0;
  logic s_prev = 1'b0, r_prev = 1'b0, busy_prev = 1'b0;
  logic plog[$];

  always @(negedge clk) begin
    chk("s_vs_model",     32'(s),     32'(m_left > 0 && m_kind));
    chk("r_vs_model",     32'(r),     32'(m_left > 0 && !m_kind));
    chk("level_vs_model", 32'(level), 32'(m_level));
    chk("busy_vs_model",  32'(busy),  32'(m_run > 0 || m_left > 0));
    chk("no_overlap",     32'(s && r), 32'(0));
    if (reset) begin
      last_fall = -1;
      last_kind = 1'b0;
    end else begin
      if ((s && !s_prev) || (r && !r_prev)) begin
        n_pulses++;
        plog.push_back(s);
        chk("alternate", 32'(s), 32'(!last_kind));
        if (last_fall >= 0) chk("pulse_gap", 32'(cyc - last_fall >= DEB + 1), 32'(1));
        last_kind = s;
        if (s) s_rise_cyc = cyc;
        else   r_rise_cyc = cyc;
      end
      if ((!s && s_prev) || (!r && r_prev)) last_fall = cyc;
      if (!s && s_prev) s_fall_cyc = cyc;
      if (busy && !busy_prev) busy_rise_cyc = cyc;
    end
    s_prev    = s;
    r_prev    = r;
    busy_prev = busy;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int k, e, mark;

  initial begin
    step(3);
    chk("reset_s",     32'(s),     32'(0));
    chk("reset_r",     32'(r),     32'(0));
    chk("reset_level", 32'(level), 32'(0));
    chk("reset_busy",  32'(busy),  32'(0));
    reset = 1'b0;
    step(5);

    // Clean rise
    din = 1'b1; k = cyc + 1; mark = n_pulses;
    step(12);
    chk("rise_s_edge",    32'(s_rise_cyc),    32'(k + 6));
    chk("rise_busy_edge", 32'(busy_rise_cyc), 32'(k + 2));
    chk("rise_s_fall",    32'(s_fall_cyc),    32'(k + 8));
    chk("rise_level",     32'(level),         32'(1));
    chk("rise_one_pulse", 32'(n_pulses - mark), 32'(1));

    din = 1'b0; k = cyc + 1;
    step(12);
    chk("fall_r_edge", 32'(r_rise_cyc), 32'(k + 6));
    chk("fall_level",  32'(level),      32'(0));

    // Bounce: two high samples, one low, then steady high
    din = 1'b1; step(2);
    din = 1'b0; step(1);
    din = 1'b1; e = cyc + 1; mark = n_pulses;
    step(12);
    chk("bounce_s_edge",    32'(s_rise_cyc),      32'(e + 6));
    chk("bounce_one_pulse", 32'(n_pulses - mark), 32'(1));
    din = 1'b0; step(12);

    // Early fall one cycle after s rises
    din = 1'b1; k = cyc + 1;
    step(7);
    chk("early_s_high", 32'(s), 32'(1));
    din = 1'b0;
    step(12);
    chk("early_s_fall", 32'(s_fall_cyc), 32'(k + 8));
    chk("early_r_edge", 32'(r_rise_cyc), 32'(k + 13));
    chk("early_level",  32'(level),      32'(0));

    // Five alternating accepted changes
    plog.delete();
    for (int i = 0; i < 5; i++) begin
      din = (i % 2 == 0);
      step(14);
    end
    chk("toggle_count", 32'(plog.size()), 32'(5));
    for (int i = 0; i < plog.size(); i++) chk("toggle_kind", 32'(plog[i]), 32'(i % 2 == 0));
    chk("toggle_level", 32'(level), 32'(1));

    // Reset in the first cycle of an r pulse
    din = 1'b0; k = cyc + 1;
    step(7);
    chk("rst_r_high", 32'(r), 32'(1));
    #1 reset = 1'b1;
    #1;
    chk("rst_r_abort",  32'(r),     32'(0));
    chk("rst_level",    32'(level), 32'(0));
    chk("rst_busy",     32'(busy),  32'(0));
    mark = n_pulses;
    step(3);
    reset = 1'b0;
    step(20);
    chk("rst_no_pulse", 32'(n_pulses - mark), 32'(0));
    chk("rst_level_low", 32'(level), 32'(0));

    // Release reset with din already high
    reset = 1'b1; din = 1'b1;
    step(3);
    reset = 1'b0; k = cyc + 1; mark = n_pulses;
    step(12);
    chk("release_s_edge",    32'(s_rise_cyc),      32'(k + 6));
    chk("release_one_pulse", 32'(n_pulses - mark), 32'(1));
    chk("release_level",     32'(level),           32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_pulse_gen.md
SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable synchronized samples needed to accept a level change (legal range 1..255).
REQ-002 The block SHALL have parameter PULSE_WIDTH, default 2, giving the width in clk cycles of each s or r pulse (legal range 1..255).
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have a port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have a port din, input, 1 bit: raw, asynchronous, bouncing switch level.
REQ-006 The block SHALL have a port s, output, 1 bit: registered set pulse for a downstream set/reset latch.
REQ-007 The block SHALL have a port r, output, 1 bit: registered reset pulse for a downstream set/reset latch.
REQ-008 The block SHALL have a port level, output, 1 bit: registered debounced level of din.
REQ-009 The block SHALL have a port busy, output, 1 bit: high while debouncing or while a pulse is active.

Function
REQ-010 The block SHALL synchronize din through two flops, sync1 then sync2; only sync2 feeds the FSM.
REQ-011 The FSM SHALL have exactly four states: LOW, DB_RISE, HIGH, DB_FALL.
REQ-012 In LOW with sync2=1, the FSM SHALL go to DB_RISE and clear the debounce counter to 0.
REQ-013 In DB_RISE with sync2=0, the FSM SHALL return to LOW with no pulse and no change to level.
REQ-014 In DB_RISE with sync2=1 and the counter below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-015 In DB_RISE with sync2=1 and the counter equal to DEBOUNCE_CYCLES-1, the FSM SHALL go to HIGH and, on that same edge, set level=1, set s=1 and load the pulse counter.
REQ-016 Latency: if din is first sampled high at edge k and stays stable, s and level SHALL rise at edge k+2+DEBOUNCE_CYCLES.
REQ-017 s SHALL stay high for exactly PULSE_WIDTH cycles, then fall.
REQ-018 In HIGH, the FSM SHALL NOT leave HIGH until the s pulse has completed; after that, sync2=0 SHALL move it to DB_FALL with the counter cleared.
REQ-019 DB_FALL SHALL mirror DB_RISE with inverted polarity:
- sync2=1 returns the FSM to HIGH with no pulse;
- the stable count completes by going to LOW, setting level=0 and starting an r pulse of PULSE_WIDTH cycles.
REQ-020 In LOW, the FSM SHALL NOT leave LOW until the r pulse has completed.
REQ-021 s and r SHALL never be high in the same cycle.
REQ-022 s and r SHALL be separated by at least DEBOUNCE_CYCLES+1 low cycles.
REQ-023 Every accepted level change SHALL produce exactly one pulse, and pulses SHALL strictly alternate s, r, s, ...
REQ-024 busy SHALL be 1 in DB_RISE, in DB_FALL, and whenever s or r is high; otherwise it SHALL be 0.
REQ-025 Counters SHALL saturate and never wrap; width is clog2 of the parameter maximum.
REQ-026 A glitch on din shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no change to level.

Reset
REQ-027 While reset=1, the block SHALL immediately (asynchronously) force:
- sync1=0, sync2=0;
- state=LOW, both counters=0;
- s=0, r=0, level=0, busy=0.
REQ-028 Reset asserted mid-pulse SHALL abort the pulse immediately; no remainder of the pulse SHALL be emitted after release.
REQ-029 After reset release with din held at 1, the block SHALL perform a normal rise debounce and emit one s pulse at latency per REQ-016.

Verification (DEBOUNCE_CYCLES=4, PULSE_WIDTH=2)
REQ-030 Clean rise: din 0->1 sampled at edge 10 -> s=1 and level=1 at edges 16-17, s=0 at 18, busy=1 from edge 12 to 17.
REQ-031 Bounce: din high for 2 cycles, low, then high steadily from edge 20 -> no pulse before edge 26; single s pulse at 26-27.
REQ-032 Early fall: din falls 1 cycle after s rises -> s completes its full 2 cycles; r rises 5 cycles after s falls; s and r never overlap.
REQ-033 Full toggle: 5 alternating accepted changes -> pulse sequence s, r, s, r, s; level matches final din=1.
REQ-034 Reset during the r pulse's first cycle -> r=0 immediately, level=0; after release with din=0, no pulses.
REQ-035 Reset released with din=1 -> single s pulse at release-edge+6; level=1 thereafter.
